// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and parameter legality.
package rst_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t PLLRST   = 2'd0;
  localparam state_t WAITLOCK = 2'd1;
  localparam state_t RELEASE  = 2'd2;
  localparam state_t RUN      = 2'd3;

  // Every delay must fit in the shared counter width, and the lock timeout must
  // leave room for a complete filter window.
  function automatic bit params_ok(input int num_ch, input int cnt_w,
                                   input int pll_rst_cyc, input int lock_filt,
                                   input int stage_dly, input int lock_tmo);
    longint lim;
    lim = longint'(1) << cnt_w;
    return (num_ch >= 1) && (cnt_w >= 1) && (cnt_w <= 32) &&
           (pll_rst_cyc >= 1) && (lock_filt >= 1) && (stage_dly >= 1) &&
           (lock_tmo > lock_filt) &&
           (longint'(pll_rst_cyc) <= lim) && (longint'(lock_filt) <= lim) &&
           (longint'(stage_dly) <= lim) && (longint'(lock_tmo) <= lim);
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Board-side signals of the reset sequencer, grouped for the PLL wrapper boundary.
interface rst_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH = 4
);
  // Level signalling only, no handshake: pll_locked is asynchronous, soft_rst_req
  // is sampled every cycle while high, and all outputs are registered levels.
  logic              pll_locked;
  logic              soft_rst_req;
  logic              pll_rst;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              all_done;
  state_t            state_dbg;

  modport master (
    input  pll_locked, soft_rst_req,
    output pll_rst, ch_rst_n, all_done, state_dbg
  );

  modport slave (
    output pll_locked, soft_rst_req,
    input  pll_rst, ch_rst_n, all_done, state_dbg
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rst_sequencer.sv
// PLL reset and staged domain-reset release, running on the free board clock.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int PLL_RST_CYC = 16,
  parameter int LOCK_FILT   = 64,
  parameter int STAGE_DLY   = 1000,
  parameter int LOCK_TMO    = 50000
) (
  input  logic             clk,
  input  logic             rst,
  rst_sequencer_if.master  bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST   = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TMO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);

  if (!params_ok(NUM_CH, CNT_W, PLL_RST_CYC, LOCK_FILT, STAGE_DLY, LOCK_TMO)) begin : g_param_err
    $error("rst_sequencer: illegal parameter combination");
  end

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rel_fire;
  logic              pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;

  // All sequencer state and every output lives in this one register block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PLLRST;
      cnt_q     <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      ch_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      ch_q      <= ch_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    rel_fire = 1'b0;
    case (state_q)
      PLLRST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = WAITLOCK;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAITLOCK: begin
        tmo_d = tmo_q + 1'b1;
        // A filter hit in the last timeout cycle still wins over the retry.
        if (lock_s && (cnt_q == FILT_LAST)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = PLLRST;
          cnt_d   = '0;
        end else begin
          cnt_d = lock_s ? cnt_q + 1'b1 : '0;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          state_d = PLLRST;
          cnt_d   = '0;
        end else if (bus.soft_rst_req) begin
          state_d = WAITLOCK;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (state_q == RELEASE) begin
          if (cnt_q == STAGE_LAST) begin
            rel_fire = 1'b1;
            cnt_d    = '0;
            idx_d    = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values are derived from the next state so they register on the same edge.
  always_comb begin
    pll_rst_d = (state_d == PLLRST);
    done_d    = (state_d == RUN);
    ch_d      = ch_q;
    if ((state_d == PLLRST) || (state_d == WAITLOCK)) begin
      ch_d = '0;
    end else if (rel_fire) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (idx_q == IDX_W'(i)) ch_d[i] = 1'b1;
      end
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.ch_rst_n  = ch_q;
  assign bus.all_done  = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed-plus-random bench for rst_sequencer against a phase/elapsed-time model.
module tb_rst_sequencer;

  localparam int NCH = 3;
  localparam int PRC = 4;
  localparam int LF  = 5;
  localparam int SD  = 8;
  localparam int TMO = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rst_sequencer_if #(.NUM_CH(NCH)) bus ();

  rst_sequencer #(
    .NUM_CH(NCH), .CNT_W(16), .PLL_RST_CYC(PRC),
    .LOCK_FILT(LF), .STAGE_DLY(SD), .LOCK_TMO(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase (0 pllrst, 1 waitlock, 2 release, 3 run), cycles spent in it,
  // consecutive synchronised-lock streak, and the two synchroniser stages.
  int m_phase, m_t, m_streak;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_streak = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge();
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.pll_locked;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        m_t++;
        if (m_t == PRC) begin m_phase = 1; m_t = 0; m_streak = 0; end
      end
      1: begin
        m_t++;
        m_streak = ls ? m_streak + 1 : 0;
        if (m_streak == LF) begin m_phase = 2; m_t = 0; end
        else if (m_t == TMO) begin m_phase = 0; m_t = 0; end
      end
      default: begin
        if (!ls) begin
          m_phase = 0; m_t = 0;
        end else if (bus.soft_rst_req) begin
          m_phase = 1; m_t = 0; m_streak = 0;
        end else if (m_phase == 2) begin
          m_t++;
          if (m_t == SD * NCH) m_phase = 3;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int exp_ch;
    exp_ch = 0;
    if (m_phase == 2) exp_ch = (1 << (m_t / SD)) - 1;
    if (m_phase == 3) exp_ch = (1 << NCH) - 1;
    check("pll_rst",   32'(bus.pll_rst),   32'(m_phase == 0));
    check("ch_rst_n",  32'(bus.ch_rst_n),  32'(exp_ch));
    check("all_done",  32'(bus.all_done),  32'(m_phase == 3));
    check("state_dbg", 32'(bus.state_dbg), 32'(m_phase));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_phase(input string tag, input int ph, input int max_cyc);
    int n;
    n = 0;
    while (m_phase != ph && n < max_cyc) begin
      tick();
      n++;
    end
    if (m_phase != ph) begin
      checks++;
      failures++;
      $error("FAIL %s timeout observed_phase=%0d expected_phase=%0d", tag, m_phase, ph);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n, t0, t1, prev;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.soft_rst_req = 1'b0;
    model_reset();
    #1;
    check_outputs();
    run(3);

    // Power-up: pll_rst falls on the 4th edge after reset release, lock from cycle 10.
    rst = 1'b0;
    n = 0;
    t0 = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) bus.pll_locked = 1'b1;
      tick();
      if (t0 == 0 && !bus.pll_rst) t0 = i;
    end
    check("pwrup_pll_rst_edges", 32'(t0), 32'(PRC));
    check("pwrup_all_done", 32'(bus.all_done), 32'd1);

    // Lock drop in RUN: channels drop three edges later.
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.ch_rst_n != '0 && n < 10) begin tick(); n++; end
    check("lockdrop_latency", 32'(n), 32'd3);
    bus.pll_locked = 1'b1;
    run($urandom_range(1, 3));
    check("lockdrop_repulse", 32'(bus.pll_rst), 32'd1);
    wait_phase("relock_run", 3, 80);

    // Glitchy lock: high 3, low 1, then steady; filter must restart.
    bus.pll_locked = 1'b0;
    wait_phase("glitch_wait", 1, 20);
    bus.pll_locked = 1'b1; run(3);
    bus.pll_locked = 1'b0; run(1);
    bus.pll_locked = 1'b1;
    wait_phase("glitch_release", 2, 30);
    run($urandom_range(SD, 2 * SD - 1));

    // Soft request after channel 0 released: no PLL pulse, sequence repeats.
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    check("soft_ch_clear", 32'(bus.ch_rst_n), 32'd0);
    check("soft_no_pll_rst", 32'(bus.pll_rst), 32'd0);
    wait_phase("soft_rerun", 3, 60);

    // Soft request together with lock loss: lock-loss path wins.
    bus.pll_locked = 1'b0;
    run(2);
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    check("soft_vs_loss_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("soft_vs_loss_ch", 32'(bus.ch_rst_n), 32'd0);

    // Lock never comes: pll_rst re-pulses every PRC+TMO cycles.
    t0 = -1; t1 = -1; prev = 1;
    for (int i = 0; i < 2 * (PRC + TMO) + 10; i++) begin
      tick();
      if (bus.pll_rst && !prev) begin
        if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i;
      end
      prev = bus.pll_rst;
    end
    check("nolock_period", 32'(t1 - t0), 32'(PRC + TMO));

    // rst asserted mid-RELEASE: outputs return to reset values immediately.
    bus.pll_locked = 1'b1;
    wait_phase("pre_rst_release", 2, 80);
    run($urandom_range(1, SD * NCH - 4));
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    run(2);
    rst = 1'b0;
    wait_phase("post_rst_run", 3, 80);

    // Random soak: occasional lock glitches and soft requests.
    for (int i = 0; i < 600; i++) begin
      bus.pll_locked   = ($urandom_range(0, 99) < 96);
      bus.soft_rst_req = ($urandom_range(0, 99) < 3);
      tick();
    end
    bus.soft_rst_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
